// File: rtl/apb_spi_bridge.sv
// apb_spi_bridge: APB3 slave feeding TX/RX byte FIFOs through the spi_if din/wr/rd/cmd handshake
module apb_spi_bridge #(
  parameter int FIFO_DEPTH  = 4,
  parameter int CFG_IRQ_BIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [7:0]  spi_din,
  output logic        spi_cmd,
  output logic        spi_wr,
  output logic        spi_rd,
  input  logic [7:0]  spi_dout,
  input  logic        spi_irq,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, CAPTURE} state_t;
  state_t state, state_nx;
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0] tx_cnt, rx_cnt;
  logic [7:0] ctrl_shadow, rd_byte;
  logic cmd_pend, irq_en, done;
  logic access, wr_acc, rd_acc, busy;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop, ctrl_wr, done_set, done_clr;
  logic [1:0] sel;
  logic unused;
  assign unused   = ^{pwdata[31:8], paddr[1:0]};
  assign sel      = paddr[3:2];
  assign access   = psel & penable;
  assign wr_acc   = access & pwrite;
  assign rd_acc   = access & ~pwrite;
  assign tx_empty = tx_cnt == '0;
  assign tx_full  = tx_cnt == (AW+1)'(FIFO_DEPTH);
  assign rx_empty = rx_cnt == '0;
  assign rx_full  = rx_cnt == (AW+1)'(FIFO_DEPTH);
  assign busy     = (state != IDLE) | cmd_pend;
  assign tx_push  = wr_acc & (sel == 2'd0) & ~tx_full;
  assign tx_pop   = state == LOAD;
  assign rx_push  = state == CAPTURE;
  assign rx_pop   = rd_acc & (sel == 2'd0) & ~rx_empty;
  assign ctrl_wr  = wr_acc & (sel == 2'd1) & ~busy;
  assign done_set = (state == CAPTURE) & tx_empty & ~tx_push;
  assign done_clr = wr_acc & (sel == 2'd3) & pwdata[1];
  assign pready   = 1'b1;
  assign pslverr  = access & ((sel == 2'd0) ? (pwrite ? tx_full : rx_empty) : (sel == 2'd1) & pwrite & busy);
  assign rd_byte  = (sel == 2'd0) ? (rx_empty ? 8'h00 : rx_mem[rx_rp]) :
                    (sel == 2'd1) ? ctrl_shadow :
                    (sel == 2'd2) ? {2'b00, busy, done, rx_full, rx_empty, tx_full, tx_empty} :
                                    {6'b0, done, irq_en};
  assign prdata   = {24'b0, rd_byte};
  assign spi_cmd  = cmd_pend;
  assign spi_wr   = state == LOAD;
  assign spi_rd   = state == CAPTURE;
  assign spi_din  = cmd_pend ? (ctrl_shadow | (8'd1 << CFG_IRQ_BIT)) : spi_wr ? tx_mem[tx_rp] : 8'h00;
  assign irq      = irq_en & done;
  // An accepted CTRL write also blocks launch so spi_cmd and spi_wr never overlap
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (~cmd_pend & ~ctrl_wr & ~tx_empty & ~rx_full) ? LOAD : IDLE;
      LOAD:    state_nx = WAIT;
      WAIT:    state_nx = spi_irq ? CAPTURE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= pwdata[7:0];
    if (rx_push) rx_mem[rx_wp] <= spi_dout;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_wp       <= '0;
      tx_rp       <= '0;
      rx_wp       <= '0;
      rx_rp       <= '0;
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      ctrl_shadow <= '0;
      cmd_pend    <= 1'b0;
      irq_en      <= 1'b0;
      done        <= 1'b0;
    end else begin
      state    <= state_nx;
      tx_wp    <= tx_wp + AW'(tx_push);
      tx_rp    <= tx_rp + AW'(tx_pop);
      rx_wp    <= rx_wp + AW'(rx_push);
      rx_rp    <= rx_rp + AW'(rx_pop);
      tx_cnt   <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      rx_cnt   <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
      cmd_pend <= ctrl_wr;
      done     <= done_set | (done & ~done_clr);
      if (ctrl_wr) ctrl_shadow <= pwdata[7:0];
      if (wr_acc && sel == 2'd3) irq_en <= pwdata[0];
    end
  end
endmodule

// File: tb/tb_apb_spi_bridge.sv
// tb_apb_spi_bridge: directed checks of the bridge against a spi_if stub that echoes ~din
module tb_apb_spi_bridge;
  logic clk = 0, rst = 1;
  logic psel = 0, penable = 0, pwrite = 0;
  logic [3:0] paddr = 0;
  logic [31:0] pwdata = 0, prdata;
  logic pready, pslverr, spi_cmd, spi_wr, spi_rd, spi_irq, irq;
  logic [7:0] spi_din, spi_dout;
  logic stall = 0;
  logic [7:0] s_byte;
  int s_cnt, rd_cnt = 0, excl_err = 0, checks = 0, failures = 0;
  logic s_busy;
  logic [7:0] wr_log[$];

  apb_spi_bridge dut (.clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .spi_din(spi_din), .spi_cmd(spi_cmd), .spi_wr(spi_wr), .spi_rd(spi_rd),
    .spi_dout(spi_dout), .spi_irq(spi_irq), .irq(irq));

  always #5 clk = ~clk;

  // spi_if stand-in: three-cycle transfer unless stalled, irq held until spi_rd
  always @(posedge clk) begin
    if (spi_rd) rd_cnt <= rd_cnt + 1;
    if (spi_wr && spi_cmd) excl_err <= excl_err + 1;
    if (rst) begin
      spi_irq <= 0; s_busy <= 0; spi_dout <= 0;
    end else begin
      if (spi_wr) begin
        s_byte <= spi_din; s_cnt <= 3; s_busy <= 1; wr_log.push_back(spi_din);
      end else if (s_busy && !stall) begin
        if (s_cnt == 0) begin spi_irq <= 1; spi_dout <= ~s_byte; s_busy <= 0; end
        else s_cnt <= s_cnt - 1;
      end
      if (spi_rd) spi_irq <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1;
    @(negedge clk); rd = prdata; err = pslverr;
    @(posedge clk); #1 psel = 0; penable = 0;
  endtask

  logic [31:0] d;
  logic e;
  int base, rb;
  bit ok;
  logic [7:0] exp_b [5] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    // reset state
    check("pready", pready, 1);
    check("irq_rst", irq, 0);
    check("din_rst", spi_din, 0);
    apb(0, 4'h8, 0, d, e); check("status_rst", d, 32'h05); check("status_rst_err", e, 0);
    // config byte and a single echoed byte
    apb(1, 4'h4, 32'h01, d, e); check("ctrl_wr_err", e, 0);
    @(negedge clk); check("spi_cmd", spi_cmd, 1); check("cmd_din", spi_din, 8'h05);
    @(posedge clk); #1;
    apb(0, 4'h4, 0, d, e); check("ctrl_rd", d, 32'h01);
    base = wr_log.size();
    apb(1, 4'h0, 32'hA5, d, e); check("push_a5_err", e, 0);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin apb(0, 4'h8, 0, d, e); ok = d[4]; end
    check("done_a5_timeout", ok, 1);
    check("wr_din_a5", (wr_log.size() > base) ? wr_log[base] : 8'hxx, 8'hA5);
    check("rd_pulses", rd_cnt, 1);
    apb(0, 4'h0, 0, d, e); check("rx_5a", d, 32'h5A); check("rx_5a_err", e, 0);
    apb(0, 4'hC, 0, d, e); check("irq_reg_done", d, 32'h2);
    apb(1, 4'hC, 32'h2, d, e);
    // fill TX while the transfer stalls; pre-cycle full rule rejects the 6th push
    stall = 1; base = wr_log.size();
    for (int i = 0; i < 6; i++) begin
      apb(1, 4'h0, 32'h11 + i, d, e);
      check($sformatf("push%0d_err", i), e, (i == 5));
    end
    stall = 0;
    repeat (80) @(posedge clk); #1;
    check("wr_count4", wr_log.size() - base, 4);
    apb(0, 4'h8, 0, d, e); check("status_rxfull", d, 32'h08);
    apb(0, 4'h0, 0, d, e); check("rx0", d, 32'hEE);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin apb(0, 4'h8, 0, d, e); ok = d[4]; end
    check("done5_timeout", ok, 1);
    check("wr_count5", wr_log.size() - base, 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("wr_order%0d", i), (wr_log.size() > base + i) ? wr_log[base + i] : 8'hxx, exp_b[i]);
    for (int i = 1; i < 5; i++) begin
      apb(0, 4'h0, 0, d, e); check($sformatf("rx%0d", i), d, {24'h0, ~exp_b[i]});
    end
    apb(0, 4'h0, 0, d, e); check("rx_empty_data", d, 0); check("rx_empty_err", e, 1);
    apb(0, 4'h8, 0, d, e); check("status_done", d, 32'h15);
    // interrupt after a 2-byte batch; CTRL rejected while busy
    apb(1, 4'hC, 32'h3, d, e);
    check("irq_cleared", irq, 0);
    stall = 1;
    apb(1, 4'h0, 32'h21, d, e);
    apb(1, 4'h0, 32'h22, d, e);
    check("irq_midbatch", irq, 0);
    apb(1, 4'h4, 32'h7F, d, e); check("ctrl_busy_err", e, 1);
    apb(0, 4'h4, 0, d, e); check("ctrl_unchanged", d, 32'h01);
    rb = rd_cnt; stall = 0; ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = irq; end
    check("irq_timeout", ok, 1);
    check("irq_after_2nd", rd_cnt - rb, 2);
    @(posedge clk); #1;
    apb(1, 4'hC, 32'h3, d, e);
    check("irq_fall", irq, 0);
    apb(0, 4'h0, 0, d, e); check("rx_de", d, 32'hDE);
    apb(0, 4'h0, 0, d, e); check("rx_dd", d, 32'hDD);
    apb(1, 4'hC, 32'h0, d, e);
    // reset while waiting on spi_irq
    stall = 1; base = wr_log.size();
    apb(1, 4'h0, 32'h31, d, e);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = (wr_log.size() > base); end
    check("launch_timeout", ok, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1; rb = rd_cnt;
    @(negedge clk);
    check("rst_no_rd", spi_rd, 0); check("rst_no_wr", spi_wr, 0);
    @(posedge clk); #1 rst = 0; stall = 0;
    repeat (10) @(posedge clk); #1;
    check("rst_rd_count", rd_cnt - rb, 0);
    check("rst_wr_count", wr_log.size() - base, 1);
    apb(0, 4'h8, 0, d, e); check("status_after_rst", d, 32'h05);
    check("wr_cmd_excl", excl_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
